// File: rtl/lsu_mem_initiator.sv
// Load/store initiator between the MEM pipeline stage and the data memory.
// Turns RV32I load/store requests into single-cycle memread/memwrite pulses,
// follows the memory's clk_stall handshake, splits misaligned accesses into
// byte accesses and merges/extends the load bytes locally.
module lsu_mem_initiator #(
    parameter int SPLIT_MISALIGNED = 1,
    parameter int MAX_WAIT         = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic        busy,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_write_data,
    output logic        mem_memwrite,
    output logic        mem_memread,
    output logic [3:0]  mem_sign_mask,
    input  logic [31:0] mem_read_data,
    input  logic        mem_clk_stall
);

    // The "next sub-access or respond" decision is taken on the DONE exit
    // cycle itself, so it does not occupy a state of its own.
    typedef enum logic [2:0] {S_IDLE, S_ISSUE, S_ACK, S_DONE, S_RESP, S_DRAIN} state_t;

    localparam logic [7:0] MAX_WAIT_C = 8'(MAX_WAIT);

    state_t      state_reg, state_next;
    logic [31:0] addr_reg, wdata_reg, data_reg, data_next;
    logic [2:0]  funct3_reg;
    logic        write_reg, split_reg;
    logic [1:0]  last_idx_reg, idx_reg, idx_next;
    logic [7:0]  cnt_reg, cnt_next, cnt_inc;

    logic        accept, req_legal, req_mis, req_bad, drain_on_reset;
    logic [1:0]  req_last;
    logic [31:0] src_addr, src_wdata;
    logic [2:0]  src_funct3;
    logic        src_write, src_split;
    logic [31:0] merged, final_rdata;

    logic        err_next, resp_valid_next, memread_next, memwrite_next;
    logic [31:0] rdata_next, mem_addr_next, mem_wdata_next;
    logic [3:0]  sign_mask_next;

    assign accept = req_valid && req_ready && !reset;

    // Request decode: legality, alignment and number of byte sub-accesses
    always_comb begin
        req_legal = (req_funct3[1:0] != 2'b11) &&
                    (req_write ? !req_funct3[2] : (req_funct3 != 3'b110));
        req_mis   = ((req_funct3[1:0] == 2'b01) && req_addr[0]) ||
                    ((req_funct3[1:0] == 2'b10) && (req_addr[1:0] != 2'b00));
        req_bad   = !req_legal || (req_mis && (SPLIT_MISALIGNED == 0));
        req_last  = !req_mis ? 2'd0 : ((req_funct3[1:0] == 2'b10) ? 2'd3 : 2'd1);
        // On the accept cycle the request is not latched yet, so use it directly
        if (state_reg == S_IDLE) begin
            src_addr   = req_addr;
            src_wdata  = req_wdata;
            src_funct3 = req_funct3;
            src_write  = req_write;
            src_split  = req_mis;
        end else begin
            src_addr   = addr_reg;
            src_wdata  = wdata_reg;
            src_funct3 = funct3_reg;
            src_write  = write_reg;
            src_split  = split_reg;
        end
        drain_on_reset = (state_reg == S_ISSUE) || (state_reg == S_ACK) ||
                         (state_reg == S_DONE) ||
                         ((state_reg == S_DRAIN) && mem_clk_stall);
    end

    // Load data merge: split accesses drop the returned byte into lane idx
    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_lane
            assign merged[gi*8 +: 8] = !split_reg ? mem_read_data[gi*8 +: 8] :
                                       (idx_reg == 2'(gi)) ? mem_read_data[7:0] :
                                       data_reg[gi*8 +: 8];
        end
    endgenerate

    // Final load result: split halfwords are extended per funct3[2]
    always_comb begin
        final_rdata = merged;
        if (write_reg) begin
            final_rdata = 32'h0;
        end else if (split_reg && (funct3_reg[1:0] == 2'b01)) begin
            final_rdata = funct3_reg[2] ? {16'h0, merged[15:0]}
                                        : {{16{merged[15]}}, merged[15:0]};
        end
    end

    // Next-state logic plus the values every registered output takes next
    always_comb begin
        state_next = state_reg;
        idx_next   = idx_reg;
        data_next  = data_reg;
        cnt_inc    = cnt_reg + 8'd1;
        err_next   = 1'b0;
        rdata_next = 32'h0;
        case (state_reg)
            S_IDLE: begin
                if (accept) begin
                    idx_next  = 2'd0;
                    data_next = 32'h0;
                    if (req_bad) begin
                        state_next = S_RESP;
                        err_next   = 1'b1;
                    end else begin
                        state_next = S_ISSUE;
                    end
                end
            end
            S_ISSUE: state_next = S_ACK;
            S_ACK: begin
                if (mem_clk_stall) begin
                    state_next = S_DONE;
                end else if (cnt_inc == MAX_WAIT_C) begin
                    state_next = S_RESP;
                    err_next   = 1'b1;
                end
            end
            S_DONE: begin
                if (!mem_clk_stall) begin
                    data_next = merged;
                    if (idx_reg == last_idx_reg) begin
                        state_next = S_RESP;
                        rdata_next = final_rdata;
                    end else begin
                        state_next = S_ISSUE;
                        idx_next   = idx_reg + 2'd1;
                    end
                end else if (cnt_inc == MAX_WAIT_C) begin
                    state_next = S_RESP;
                    err_next   = 1'b1;
                end
            end
            S_RESP:  state_next = S_IDLE;
            S_DRAIN: if (!mem_clk_stall) state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase

        // Phase counter restarts whenever a new state is entered
        cnt_next = (state_next != state_reg) ? 8'd0 : cnt_inc;

        resp_valid_next = (state_next == S_RESP);
        memread_next    = 1'b0;
        memwrite_next   = 1'b0;
        mem_addr_next   = 32'h0;
        mem_wdata_next  = 32'h0;
        sign_mask_next  = 4'b0000;
        if (state_next == S_ISSUE) begin
            memread_next  = !src_write;
            memwrite_next = src_write;
            mem_addr_next = src_addr + {30'h0, idx_next};
            if (src_split) begin
                sign_mask_next = 4'b0001;
                if (src_write) mem_wdata_next = {24'h0, src_wdata[{idx_next, 3'b000} +: 8]};
            end else begin
                sign_mask_next[3]   = !src_write && !src_funct3[2] && (src_funct3[1:0] != 2'b10);
                sign_mask_next[2:0] = (src_funct3[1:0] == 2'b00) ? 3'b001 :
                                      (src_funct3[1:0] == 2'b01) ? 3'b011 : 3'b111;
                if (src_write) mem_wdata_next = src_wdata;
            end
        end
    end

    // Request field capture on accept
    always_ff @(posedge clk) begin
        if (accept) begin
            addr_reg     <= req_addr;
            wdata_reg    <= req_wdata;
            funct3_reg   <= req_funct3;
            write_reg    <= req_write;
            split_reg    <= req_mis;
            last_idx_reg <= req_last;
        end
    end

    // State and registered outputs; reset mid-access waits out the memory in DRAIN
    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg      <= drain_on_reset ? S_DRAIN : S_IDLE;
            req_ready      <= !drain_on_reset;
            busy           <= drain_on_reset;
            idx_reg        <= 2'd0;
            data_reg       <= 32'h0;
            cnt_reg        <= 8'd0;
            resp_valid     <= 1'b0;
            resp_rdata     <= 32'h0;
            resp_err       <= 1'b0;
            mem_addr       <= 32'h0;
            mem_write_data <= 32'h0;
            mem_memwrite   <= 1'b0;
            mem_memread    <= 1'b0;
            mem_sign_mask  <= 4'b0000;
        end else begin
            state_reg      <= state_next;
            req_ready      <= (state_next == S_IDLE);
            busy           <= (state_next != S_IDLE);
            idx_reg        <= idx_next;
            data_reg       <= data_next;
            cnt_reg        <= cnt_next;
            resp_valid     <= resp_valid_next;
            resp_rdata     <= rdata_next;
            resp_err       <= err_next;
            mem_addr       <= mem_addr_next;
            mem_write_data <= mem_wdata_next;
            mem_memwrite   <= memwrite_next;
            mem_memread    <= memread_next;
            mem_sign_mask  <= sign_mask_next;
        end
    end

endmodule

// File: doc/lsu_mem_initiator.md
Name: lsu_mem_initiator

Overview:
- Load/store initiator that sits between the CPU pipeline's MEM stage and the data memory.
- Converts RV32I load/store requests (funct3, address, store data) into the data memory's single-cycle memread/memwrite + sign_mask request protocol.
- Tracks the memory's clk_stall handshake and returns the load result or store completion to the pipeline.
- Splits misaligned accesses into sequential byte accesses and merges/sign-extends load bytes locally.

Parameters:
- SPLIT_MISALIGNED, 1, 1 = split misaligned accesses into byte accesses; 0 = respond with error and make no memory access.
- MAX_WAIT, 16, cycle limit for each handshake phase before abort with error (range 4..255).

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- req_valid  in  1  pipeline request present
- req_ready  out  1  unit can accept a request (IDLE only)
- req_write  in  1  1 = store, 0 = load
- req_funct3  in  3  RV32I load/store funct3
- req_addr  in  32  byte address
- req_wdata  in  32  store data
- resp_valid  out  1  one-cycle completion pulse
- resp_rdata  out  32  load result; 0 for stores
- resp_err  out  1  valid with resp_valid: illegal funct3, misaligned with SPLIT_MISALIGNED=0, or timeout
- busy  out  1  high in every state except IDLE; drives the pipeline stall
- mem_addr  out  32  memory address
- mem_write_data  out  32  store data, right-justified
- mem_memwrite  out  1  write request pulse
- mem_memread  out  1  read request pulse
- mem_sign_mask  out  4  [3] = signed, [2:0] = 001 byte / 011 half / 111 word
- mem_read_data  in  32  memory read result
- mem_clk_stall  in  1  memory busy

Behaviour:
- All outputs are registered. Reset value of every output is 0, except req_ready=1.
- Reset mid-operation:
  - Drop any request and do not issue resp_valid.
  - Enter DRAIN and remain there until mem_clk_stall=0, then go to IDLE.
- funct3 decode:
  - Loads: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU.
  - Stores: 000 SB, 001 SH, 010 SW.
  - Any other funct3 → resp_valid + resp_err one cycle after accept; no memory access.
- Alignment rules:
  - Halfword is aligned if addr[0]=0.
  - Word is aligned if addr[1:0]=0.
  - Aligned access = 1 sub-access with native size.
  - Misaligned access = N byte sub-accesses (N=2 for half, N=4 for word) at addr, addr+1, …, in ascending order. Addresses wrap modulo 2^32.
- Request protocol:
  - Accept when req_valid & req_ready.
  - Latch addr, wdata, funct3, write, and sub-access count.
- State machine:
  - IDLE → ISSUE on accept.
  - ISSUE:
    - Drive mem_memread or mem_memwrite high for exactly one cycle.
    - mem_addr = current byte address.
    - Sign_mask: native size, with [3]=signed for aligned accesses; 4'b0001 for split sub-accesses.
    - Store data: mem_write_data = req_wdata for aligned accesses; byte k of req_wdata in [7:0] (upper bits 0) for split sub-access k.
    - Next state: ACK.
  - ACK: wait for mem_clk_stall=1, then go to DONE.
  - DONE:
    - Wait for mem_clk_stall=0.
    - On that cycle, a load captures mem_read_data: the whole word if aligned, [7:0] into byte lane k if split.
    - Then go to NEXT.
  - NEXT:
    - More sub-accesses remaining → ISSUE.
    - Otherwise → RESP.
  - RESP:
    - resp_valid=1 for one cycle.
    - Split loads are sign- or zero-extended from the merged halfword per funct3; aligned results are passed unchanged.
    - Next state: IDLE.
- Timeout: a cycle counter restarts on entry to ACK and again on entry to DONE. If it reaches MAX_WAIT, abort → RESP with resp_err=1 and resp_rdata=0.
- mem_memread and mem_memwrite are never high together and are never high outside ISSUE.
- Latency, counted from the accept edge:
  - Aligned access: ISSUE in cycle 1, stall high in cycles 2–3, capture in cycle 4, resp_valid in cycle 5.
  - Each extra split sub-access adds 4 cycles.
- req_valid held while busy is ignored. A new request can be accepted in the cycle after resp_valid.

Test Plan:
- Aligned LW at 0x0000_0104, memory returns 0xDEADBEEF with a 2-cycle stall → one mem_memread pulse, sign_mask=0111, resp_rdata=0xDEADBEEF, resp_valid at accept+5, resp_err=0.
- LB at 0x0000_0103, memory returns 0xFFFFFF80 → sign_mask=1001, resp_rdata=0xFFFFFF80. Same access with LBU → sign_mask=0001.
- Misaligned LH at 0x0000_0011, bytes 0x34 then 0x92 → two byte reads at 0x11 and 0x12, resp_rdata=0xFFFF9234, resp_valid at accept+9.
- Misaligned SW 0xAABBCCDD at 0x0000_0022 → four mem_memwrite pulses at 0x22, 0x23, 0x24, 0x25 with data 0xDD, 0xCC, 0xBB, 0xAA; resp_err=0.
- Memory never raises mem_clk_stall, MAX_WAIT=16 → resp_valid with resp_err=1 at accept+18; funct3=011 → resp_err at accept+1, no memory pulse.
- Reset asserted while in DONE with stall still high → no resp_valid; busy stays high until stall falls; next request is issued correctly.
